eth_demux_ctrl: RTL and testbench

// - Header-side classifier/scheduler for the Ethernet demultiplexer: buffers one frame header, scans a

---
 rtl/eth_demux_ctrl_pkg.sv | 47 ++++
 rtl/eth_demux_ctrl_rule_match.sv | 20 ++
 rtl/eth_demux_ctrl.sv | 157 +++++++++++++++
 tb/tb_eth_demux_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_demux_ctrl_pkg.sv
// Shared types for the Ethernet demux header controller: rule layout, FSM states.
package eth_demux_ctrl_pkg;

    localparam int RULE_W = 100;
    localparam int SEL_W  = 2;

    // Bit offsets of the fields inside a 100-bit rule word
    localparam int EN_BIT      = 99;
    localparam int MAC_EN_BIT  = 98;
    localparam int DROP_BIT    = 97;
    localparam int SEL_LSB     = 95;
    localparam int TVAL_LSB    = 79;
    localparam int TMASK_LSB   = 63;
    localparam int RSVD_LSB    = 48;
    localparam int MAC_LSB     = 0;

    // Stored rule entry; the reserved field is not kept
    typedef struct packed {
        logic             en;
        logic             mac_en;
        logic             drop;
        logic [SEL_W-1:0] sel;
        logic [15:0]      type_val;
        logic [15:0]      type_mask;
        logic [47:0]      mac_val;
    } rule_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Unpack a raw configuration word into a stored rule entry
    function automatic rule_t decode_rule(input logic [RULE_W-1:0] raw);
        rule_t r;
        r.en        = raw[EN_BIT];
        r.mac_en    = raw[MAC_EN_BIT];
        r.drop      = raw[DROP_BIT];
        r.sel       = raw[SEL_LSB +: SEL_W];
        r.type_val  = raw[TVAL_LSB +: 16];
        r.type_mask = raw[TMASK_LSB +: 16];
        r.mac_val   = raw[MAC_LSB +: 48];
        return r;
    endfunction

endpackage

// File: rtl/eth_demux_ctrl_rule_match.sv
// Single-rule comparator: masked ethertype match plus optional exact dest MAC match.
module eth_demux_ctrl_rule_match (
    input  logic        en,
    input  logic        mac_en,
    input  logic [15:0] type_val,
    input  logic [15:0] type_mask,
    input  logic [47:0] mac_val,
    input  logic [15:0] eth_type,
    input  logic [47:0] dest_mac,
    output logic        hit
);

    logic type_ok;
    logic mac_ok;

    assign type_ok = ((eth_type ^ type_val) & type_mask) == 16'h0000;
    assign mac_ok  = !mac_en || (dest_mac == mac_val);
    assign hit     = en && type_ok && mac_ok;

endmodule

// File: rtl/eth_demux_ctrl.sv
// Ethernet demux header controller: captures one header, scans the rule table one
// entry per cycle (first hit wins), then holds the header with select/drop until
// the demux accepts it.
// Optional per-port/drop frame counters: define ETH_DEMUX_CTRL_STATS_EN.
module eth_demux_ctrl
    import eth_demux_ctrl_pkg::*;
#(
    parameter int M_COUNT    = 4,
    parameter int RULE_COUNT = 8,
    parameter int RULE_AW    = 3,
    parameter int CL_M       = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_eth_hdr_valid,
    output logic                s_eth_hdr_ready,
    input  logic [47:0]         s_eth_dest_mac,
    input  logic [47:0]         s_eth_src_mac,
    input  logic [15:0]         s_eth_type,
    output logic                m_eth_hdr_valid,
    input  logic                m_eth_hdr_ready,
    output logic [47:0]         m_eth_dest_mac,
    output logic [47:0]         m_eth_src_mac,
    output logic [15:0]         m_eth_type,
    output logic [CL_M-1:0]     m_select,
    output logic                m_drop,
    output logic                m_enable,
    input  logic                ctrl_enable,
    input  logic                cfg_wr_en,
    output logic                cfg_ready,
    input  logic [RULE_AW-1:0]  cfg_addr,
    input  logic [RULE_W-1:0]   cfg_rule,
    input  logic [CL_M-1:0]     cfg_def_select,
    input  logic                cfg_def_drop
`ifdef ETH_DEMUX_CTRL_STATS_EN
    ,
    output logic [M_COUNT*32-1:0] stat_frames,
    output logic [31:0]           stat_drops
`endif
);

    state_t             state_q, state_d;
    rule_t              rules [RULE_COUNT];
    rule_t              cur_rule;
    logic [RULE_AW-1:0] scan_idx;
    logic               scan_last;
    logic               cur_hit;
    logic               capture;
    logic               out_hs;
    logic               cfg_rsvd_unused;

    // Reserved rule bits carry no meaning here
    assign cfg_rsvd_unused = ^cfg_rule[RSVD_LSB +: 15];

    assign s_eth_hdr_ready = (state_q == ST_IDLE) && ctrl_enable && !rst;
    assign capture         = s_eth_hdr_valid && s_eth_hdr_ready;
    assign m_eth_hdr_valid = (state_q == ST_OUT);
    assign out_hs          = m_eth_hdr_valid && m_eth_hdr_ready;
    assign cfg_ready       = (state_q != ST_SCAN);
    assign m_enable        = ctrl_enable;

    assign cur_rule  = rules[scan_idx];
    assign scan_last = (scan_idx == RULE_AW'(RULE_COUNT - 1));

    eth_demux_ctrl_rule_match u_match (
        .en        (cur_rule.en),
        .mac_en    (cur_rule.mac_en),
        .type_val  (cur_rule.type_val),
        .type_mask (cur_rule.type_mask),
        .mac_val   (cur_rule.mac_val),
        .eth_type  (m_eth_type),
        .dest_mac  (m_eth_dest_mac),
        .hit       (cur_hit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: capture -> scan until hit or table end -> hold until accepted
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (capture) state_d = ST_SCAN;
            ST_SCAN: if (cur_hit || scan_last) state_d = ST_OUT;
            ST_OUT:  if (m_eth_hdr_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Rule table; only the enable bits need a known reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RULE_COUNT; i++) rules[i].en <= 1'b0;
        end else if (cfg_wr_en && cfg_ready) begin
            rules[cfg_addr] <= decode_rule(cfg_rule);
        end
    end

    // Header copy, loaded on capture and held through scan and output
    always_ff @(posedge clk) begin
        if (capture) begin
            m_eth_dest_mac <= s_eth_dest_mac;
            m_eth_src_mac  <= s_eth_src_mac;
            m_eth_type     <= s_eth_type;
        end
    end

    // Scan index and latched classification result
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx <= '0;
            m_select <= '0;
            m_drop   <= 1'b0;
        end else if (capture) begin
            scan_idx <= '0;
        end else if (state_q == ST_SCAN) begin
            if (cur_hit) begin
                // A select outside the port range cannot be routed, so drop it
                m_select <= CL_M'(cur_rule.sel);
                m_drop   <= cur_rule.drop || (32'(cur_rule.sel) >= M_COUNT);
            end else if (scan_last) begin
                m_select <= cfg_def_select;
                m_drop   <= cfg_def_drop;
            end else begin
                scan_idx <= scan_idx + 1'b1;
            end
        end
    end

`ifdef ETH_DEMUX_CTRL_STATS_EN
    logic [31:0] frame_cnt [M_COUNT];

    for (genvar p = 0; p < M_COUNT; p++) begin : g_stat
        // Count frames delivered to port p
        always_ff @(posedge clk) begin
            if (rst)
                frame_cnt[p] <= '0;
            else if (out_hs && !m_drop && (m_select == CL_M'(p)))
                frame_cnt[p] <= frame_cnt[p] + 32'd1;
        end
        assign stat_frames[p*32 +: 32] = frame_cnt[p];
    end

    // Count dropped frames
    always_ff @(posedge clk) begin
        if (rst)         stat_drops <= '0;
        else if (out_hs && m_drop) stat_drops <= stat_drops + 32'd1;
    end
`else
    logic out_hs_unused;
    assign out_hs_unused = out_hs;
`endif

endmodule

// File: tb/tb_eth_demux_ctrl.sv
// Self-checking bench for eth_demux_ctrl: directed scenarios plus randomized
// frames checked against a first-hit rule table model.
module tb_eth_demux_ctrl;

    localparam int RC = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_eth_hdr_valid = 1'b0;
    logic         s_eth_hdr_ready;
    logic [47:0]  s_eth_dest_mac = '0;
    logic [47:0]  s_eth_src_mac = '0;
    logic [15:0]  s_eth_type = '0;
    logic         m_eth_hdr_valid;
    logic         m_eth_hdr_ready = 1'b0;
    logic [47:0]  m_eth_dest_mac;
    logic [47:0]  m_eth_src_mac;
    logic [15:0]  m_eth_type;
    logic [1:0]   m_select;
    logic         m_drop;
    logic         m_enable;
    logic         ctrl_enable = 1'b1;
    logic         cfg_wr_en = 1'b0;
    logic         cfg_ready;
    logic [2:0]   cfg_addr = '0;
    logic [99:0]  cfg_rule = '0;
    logic [1:0]   cfg_def_select = '0;
    logic         cfg_def_drop = 1'b0;
`ifdef ETH_DEMUX_CTRL_STATS_EN
    logic [127:0] stat_frames;
    logic [31:0]  stat_drops;
`endif

    eth_demux_ctrl dut (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
        .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
        .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
        .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
        .m_select(m_select), .m_drop(m_drop), .m_enable(m_enable),
        .ctrl_enable(ctrl_enable), .cfg_wr_en(cfg_wr_en), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_rule(cfg_rule),
        .cfg_def_select(cfg_def_select),
`ifdef ETH_DEMUX_CTRL_STATS_EN
        .stat_frames(stat_frames), .stat_drops(stat_drops),
`endif
        .cfg_def_drop(cfg_def_drop)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference rule table
    bit          r_en [RC];
    bit          r_macen [RC];
    bit          r_drop [RC];
    logic [1:0]  r_sel [RC];
    logic [15:0] r_tv [RC];
    logic [15:0] r_tm [RC];
    logic [47:0] r_mac [RC];

    // Expectations of the frame currently held at the output
    logic [1:0]  e_sel;
    bit          e_drop;
    logic [47:0] e_dest, e_src;
    logic [15:0] e_type;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // First enabled rule whose masked type and optional MAC match decides; otherwise defaults
    function automatic void predict(input logic [15:0] t, input logic [47:0] d,
                                    output logic [1:0] sel, output bit drop, output int lat);
        for (int i = 0; i < RC; i++) begin
            if (r_en[i] && ((t & r_tm[i]) == (r_tv[i] & r_tm[i])) && (!r_macen[i] || d == r_mac[i])) begin
                sel = r_sel[i];
                drop = r_drop[i];
                lat = i + 1;
                return;
            end
        end
        sel = cfg_def_select;
        drop = cfg_def_drop;
        lat = RC;
    endfunction

    task automatic wr_rule(input int a, input bit en, input bit macen, input bit drp,
                           input logic [1:0] sel, input logic [15:0] tv, input logic [15:0] tm,
                           input logic [47:0] mac);
        cfg_addr = 3'(a);
        cfg_rule = {en, macen, drp, sel, tv, tm, 15'h5A5A, mac};
        cfg_wr_en = 1'b1;
        tick();
        cfg_wr_en = 1'b0;
        r_en[a] = en; r_macen[a] = macen; r_drop[a] = drp;
        r_sel[a] = sel; r_tv[a] = tv; r_tm[a] = tm; r_mac[a] = mac;
    endtask

    task automatic clear_model();
        for (int i = 0; i < RC; i++) r_en[i] = 1'b0;
    endtask

    // Present a header, wait for capture and classification, check the held output
    task automatic start_frame(input logic [15:0] t, input logic [47:0] d, input bit en_off);
        int lat, elat;
        int w;
        e_type = t; e_dest = d; e_src = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        s_eth_type = t; s_eth_dest_mac = d; s_eth_src_mac = e_src;
        s_eth_hdr_valid = 1'b1;
        w = 0;
        while (!s_eth_hdr_ready && w < 40) begin tick(); w++; end
        if (!s_eth_hdr_ready) begin
            chk("capture_timeout", 0, 1);
            s_eth_hdr_valid = 1'b0;
            return;
        end
        predict(t, d, e_sel, e_drop, elat);
        tick();
        s_eth_hdr_valid = 1'b0;
        s_eth_type = ~t;
        if (en_off) ctrl_enable = 1'b0;
        lat = 0;
        while (!m_eth_hdr_valid && lat < RC + 4) begin tick(); lat++; end
        chk("latency", 64'(lat), 64'(elat));
        chk("select", 64'(m_select), 64'(e_sel));
        chk("drop", 64'(m_drop), 64'(e_drop));
        chk("dest", 64'(m_eth_dest_mac), 64'(e_dest));
        chk("src", 64'(m_eth_src_mac), 64'(e_src));
        chk("type", 64'(m_eth_type), 64'(e_type));
        chk("enable", 64'(m_enable), 64'(ctrl_enable));
    endtask

    task automatic finish_frame();
        m_eth_hdr_ready = 1'b1;
        tick();
        m_eth_hdr_ready = 1'b0;
        chk("valid_after_hs", 64'(m_eth_hdr_valid), 64'd0);
        chk("ready_after_hs", 64'(s_eth_hdr_ready), 64'(ctrl_enable));
    endtask

    initial begin
        logic [15:0] types [4];
        logic [15:0] masks [3];
        logic [47:0] macs [2];

        // Reset state
        tick(2);
        chk("rst_s_ready", 64'(s_eth_hdr_ready), 64'd0);
        chk("rst_m_valid", 64'(m_eth_hdr_valid), 64'd0);
        chk("rst_select", 64'(m_select), 64'd0);
        chk("rst_drop", 64'(m_drop), 64'd0);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        rst = 1'b0;
        clear_model();
        tick();
        chk("idle_s_ready", 64'(s_eth_hdr_ready), 64'd1);

        // No rules: defaults after full table scan
        cfg_def_select = 2'd1; cfg_def_drop = 1'b1;
        start_frame(16'h0800, 48'h1111_2222_3333, 1'b0);
        chk("scan_cfg_ready_out", 64'(cfg_ready), 64'd1);
        finish_frame();

        // Rule 0 exact ethertype
        cfg_def_drop = 1'b0; cfg_def_select = 2'd0;
        wr_rule(0, 1, 0, 0, 2'd2, 16'h0800, 16'hFFFF, 48'h0);
        start_frame(16'h0800, 48'h1111_2222_3333, 1'b0);
        finish_frame();

        // Rule 3 MAC match, rule 5 type wildcard
        wr_rule(3, 1, 1, 0, 2'd3, 16'h0000, 16'h0000, 48'h0200_0000_0001);
        wr_rule(5, 1, 0, 0, 2'd0, 16'h0000, 16'h0000, 48'h0);
        start_frame(16'h86DD, 48'h0200_0000_0001, 1'b0);
        finish_frame();
        start_frame(16'h86DD, 48'h0200_0000_0002, 1'b0);
        finish_frame();

        // Backpressure: output stable, no capture, config write in OUT affects next frame only
        s_eth_hdr_valid = 1'b0;
        start_frame(16'h0800, 48'hAAAA_BBBB_CCCC, 1'b0);
        s_eth_hdr_valid = 1'b1;
        s_eth_type = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) wr_rule(0, 1, 0, 1, 2'd1, 16'h0800, 16'hFFFF, 48'h0);
            else tick();
            chk("hold_valid", 64'(m_eth_hdr_valid), 64'd1);
            chk("hold_select", 64'(m_select), 64'(e_sel));
            chk("hold_drop", 64'(m_drop), 64'(e_drop));
            chk("hold_s_ready", 64'(s_eth_hdr_ready), 64'd0);
        end
        chk("hold_type", 64'(m_eth_type), 64'(e_type));
        s_eth_hdr_valid = 1'b0;
        finish_frame();
        start_frame(16'h0800, 48'hAAAA_BBBB_CCCC, 1'b0);
        finish_frame();

        // Enable dropped mid-scan: frame completes, new capture blocked
        start_frame(16'h9999, 48'h0200_0000_0009, 1'b1);
        finish_frame();
        s_eth_hdr_valid = 1'b1;
        tick(3);
        chk("disabled_s_ready", 64'(s_eth_hdr_ready), 64'd0);
        chk("disabled_no_capture", 64'(m_eth_hdr_valid), 64'd0);
        s_eth_hdr_valid = 1'b0;
        ctrl_enable = 1'b1;

        // Reset during scan discards the frame and clears rules
        wr_rule(5, 0, 0, 0, 2'd0, 16'h0, 16'h0, 48'h0);
        s_eth_type = 16'h4444; s_eth_dest_mac = 48'h5;
        s_eth_hdr_valid = 1'b1;
        tick();
        s_eth_hdr_valid = 1'b0;
        tick(2);
        chk("scan_cfg_ready", 64'(cfg_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < 10; i++) chk("rst_scan_no_valid", 64'(m_eth_hdr_valid), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_eth_hdr_valid !== 1'b0) chk("rst_scan_valid_rise", 64'(m_eth_hdr_valid), 64'd0);
        end
        cfg_def_select = 2'd2; cfg_def_drop = 1'b0;
        start_frame(16'h0800, 48'h0200_0000_0001, 1'b0);
        finish_frame();

        // Randomized rules and headers
        types = '{16'h0800, 16'h86DD, 16'h0806, 16'h88F7};
        masks = '{16'hFFFF, 16'hFF00, 16'h0000};
        macs  = '{48'h0200_0000_0001, 48'h0200_0000_0002};
        for (int f = 0; f < 40; f++) begin
            if (f % 3 == 0) begin
                wr_rule(int'($urandom_range(0, RC - 1)), ($urandom_range(0, 3) != 0),
                        1'($urandom), 1'($urandom), 2'($urandom),
                        types[$urandom_range(0, 3)] ^ 16'($urandom_range(0, 1)),
                        masks[$urandom_range(0, 2)], macs[$urandom_range(0, 1)]);
                cfg_def_select = 2'($urandom); cfg_def_drop = 1'($urandom);
            end
            start_frame(($urandom_range(0, 4) == 0) ? 16'($urandom) : types[$urandom_range(0, 3)],
                        ($urandom_range(0, 3) == 0) ? {$urandom, 16'($urandom)} & 48'hFFFF_FFFF_FFFF
                                                    : macs[$urandom_range(0, 1)], 1'b0);
            tick(int'($urandom_range(0, 2)));
            finish_frame();
        end

`ifdef ETH_DEMUX_CTRL_STATS_EN
        // Counters: 5 frames to port 1, 2 drops
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        chk("stat_rst_drops", 64'(stat_drops), 64'd0);
        cfg_def_select = 2'd0; cfg_def_drop = 1'b1;
        wr_rule(2, 1, 0, 0, 2'd1, 16'h1234, 16'hFFFF, 48'h0);
        for (int i = 0; i < 7; i++) begin
            start_frame((i < 5) ? 16'h1234 : 16'h9876, 48'h7, 1'b0);
            finish_frame();
        end
        chk("stat_frames1", 64'(stat_frames[63:32]), 64'd5);
        chk("stat_frames0", 64'(stat_frames[31:0]), 64'd0);
        chk("stat_drops", 64'(stat_drops), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
